// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO pair and services MTHI/MTLO.
// Defining MULDIV_MADD_EN adds MADD/MADDU (op 100/101), which accumulate into {HI,LO}.
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_div;
    logic                 r_zdiv;
    logic                 r_neg_res;
    logic                 r_neg_a;
    logic [WIDTH-1:0]     r_opnd;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_dvz;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
`ifdef MULDIV_MADD_EN
    logic                 r_madd;
`endif

    logic                 w_op_valid;
    logic                 w_op_signed;
    logic                 w_op_mul;
    logic                 w_b_zero;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_abs;
    logic [WIDTH-1:0]     w_b_abs;
    logic [WIDTH:0]       w_add_sum;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_acc_mul;
    logic [2*WIDTH-1:0]   w_acc_div;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_prod_acc;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    function automatic logic [WIDTH-1:0] f_cneg(input logic [WIDTH-1:0] x, input logic en);
        return en ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_cneg2(input logic [2*WIDTH-1:0] x, input logic en);
        return en ? (~x + 1'b1) : x;
    endfunction

`ifdef MULDIV_MADD_EN
    assign w_op_valid = ~op[2] | ~op[1];
`else
    assign w_op_valid = ~op[2];
`endif
    assign w_op_signed = ~op[0];
    assign w_op_mul    = ~op[1];
    assign w_b_zero    = (b == '0);
    assign w_a_neg     = w_op_signed & a[WIDTH-1];
    assign w_b_neg     = w_op_signed & b[WIDTH-1];
    assign w_a_abs     = f_cneg(a, w_a_neg);
    assign w_b_abs     = f_cneg(b, w_b_neg);

    // Multiply step: low half holds the multiplier, shifted out LSB-first.
    assign w_add_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_acc_mul = {w_add_sum, r_acc[WIDTH-1:1]};

    // Restoring divide step: upper half is the partial remainder, low half the dividend/quotient.
    assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_opnd};
    assign w_acc_div = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                     : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

    assign w_prod = f_cneg2(r_acc, r_neg_res);
    assign w_quo  = f_cneg(r_acc[WIDTH-1:0], r_neg_res);
    assign w_rem  = f_cneg(r_acc[2*WIDTH-1:WIDTH], r_neg_a);
`ifdef MULDIV_MADD_EN
    assign w_prod_acc = r_madd ? ({r_hi, r_lo} + w_prod) : w_prod;
`else
    assign w_prod_acc = w_prod;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_div     <= 1'b0;
            r_zdiv    <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_a   <= 1'b0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dvz     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
`ifdef MULDIV_MADD_EN
            r_madd    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && w_op_valid) begin
                        r_state   <= S_RUN;
                        r_busy    <= 1'b1;
                        r_cnt     <= CNT_W'(WIDTH);
                        r_div     <= ~w_op_mul;
                        r_zdiv    <= ~w_op_mul & w_b_zero;
                        r_dvz     <= 1'b0;
                        r_neg_a   <= w_a_neg;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_acc     <= {{WIDTH{1'b0}}, (w_op_mul ? w_b_abs : w_a_abs)};
`ifdef MULDIV_MADD_EN
                        r_madd    <= op[2];
`endif
                        // A zero divisor makes the iterations meaningless, so the
                        // original dividend is parked in r_opnd for the HI result.
                        if (w_op_mul)
                            r_opnd <= w_a_abs;
                        else if (w_b_zero)
                            r_opnd <= a;
                        else
                            r_opnd <= w_b_abs;
                    end else begin
                        if (hi_we)
                            r_hi <= wdata;
                        if (lo_we)
                            r_lo <= wdata;
                    end
                end
                S_RUN: begin
                    r_acc <= r_div ? w_acc_div : w_acc_mul;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    if (!r_div) begin
                        {r_hi, r_lo} <= w_prod_acc;
                    end else if (r_zdiv) begin
                        r_hi  <= r_opnd;
                        r_lo  <= '1;
                        r_dvz <= 1'b1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dvz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed-vector bench for mips_muldiv_unit (WIDTH=32); MADD checks build when MULDIV_MADD_EN is defined.
module tb_mips_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one operation from a negedge and waits (bounded) for done.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int nbusy, output logic dvz1);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dvz1  = div_by_zero;
        lat   = 1;
        nbusy = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset dvz: got %b expected 0", div_by_zero); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset hi: got %h expected 0", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset lo: got %h expected 0", lo); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu_max();
        int lat, nb; logic z;
        do_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, nb, z);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL multu latency: got %0d expected 34", lat); end
        n_checks++; if (nb !== 33) begin n_fail++; $display("FAIL multu busy cycles: got %0d expected 33", nb); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL multu busy at done: got %b expected 0", busy); end
        n_checks++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu hi: got %h expected fffffffe", hi); end
        n_checks++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL multu lo: got %h expected 00000001", lo); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu done pulse width: got %b expected 0", done); end
    endtask

    task automatic test_signed();
        int lat, nb; logic z;
        do_op(3'b000, 32'hFFFFFFFD, 32'd7, lat, nb, z);
        n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult -3*7 hi: got %h expected ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult -3*7 lo: got %h expected ffffffeb", lo); end
        // Chained from the done cycle: start coinciding with done must be accepted.
        do_op(3'b010, 32'hFFFFFFF9, 32'd2, lat, nb, z);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL div back-to-back latency: got %0d expected 34", lat); end
        n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div -7/2 lo: got %h expected fffffffd", lo); end
        n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div -7/2 hi: got %h expected ffffffff", hi); end
        do_op(3'b011, 32'd7, 32'd2, lat, nb, z);
        n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL divu 7/2 lo: got %h expected 3", lo); end
        n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL divu 7/2 hi: got %h expected 1", hi); end
        do_op(3'b010, 32'd7, 32'hFFFFFFFE, lat, nb, z);
        n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div 7/-2 lo: got %h expected fffffffd", lo); end
        n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL div 7/-2 hi: got %h expected 1", hi); end
        do_op(3'b010, 32'h80000000, 32'hFFFFFFFF, lat, nb, z);
        n_checks++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL div overflow lo: got %h expected 80000000", lo); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL div overflow hi: got %h expected 0", hi); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL div overflow dvz: got %b expected 0", div_by_zero); end
        do_op(3'b000, 32'h80000000, 32'h80000000, lat, nb, z);
        n_checks++; if (hi !== 32'h40000000) begin n_fail++; $display("FAIL mult minneg^2 hi: got %h expected 40000000", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL mult minneg^2 lo: got %h expected 0", lo); end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int lat, nb; logic z;
        do_op(3'b011, 32'd5, 32'd0, lat, nb, z);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL divu by zero latency: got %0d expected 34", lat); end
        n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL divu by zero dvz: got %b expected 1", div_by_zero); end
        n_checks++; if (hi !== 32'd5) begin n_fail++; $display("FAIL divu by zero hi: got %h expected 5", hi); end
        n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu by zero lo: got %h expected ffffffff", lo); end
        do_op(3'b010, 32'hFFFFFFFB, 32'd0, lat, nb, z);
        n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL div by zero dvz at accept: got %b expected 0", z); end
        n_checks++; if (hi !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL div -5/0 hi: got %h expected fffffffb", hi); end
        n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div -5/0 lo: got %h expected ffffffff", lo); end
        repeat (3) @(negedge clk);
        n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dvz sticky: got %b expected 1", div_by_zero); end
    endtask

    task automatic test_op1xx();
        int nbusy;
`ifdef MULDIV_MADD_EN
        int lat, nb; logic z;
        lo_we = 1'b1; wdata = 32'd10; @(negedge clk); lo_we = 1'b0;
        hi_we = 1'b1; wdata = 32'd0;  @(negedge clk); hi_we = 1'b0;
        do_op(3'b100, 32'd3, 32'd4, lat, nb, z);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL madd latency: got %0d expected 34", lat); end
        n_checks++; if (lo !== 32'd22) begin n_fail++; $display("FAIL madd 3*4 lo: got %h expected 16", lo); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL madd 3*4 hi: got %h expected 0", hi); end
        do_op(3'b100, 32'hFFFFFFFF, 32'd1, lat, nb, z);
        n_checks++; if (lo !== 32'd21) begin n_fail++; $display("FAIL madd -1 lo: got %h expected 15", lo); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL madd -1 hi: got %h expected 0", hi); end
        do_op(3'b101, 32'hFFFFFFFF, 32'd1, lat, nb, z);
        n_checks++; if (lo !== 32'h00000014) begin n_fail++; $display("FAIL maddu lo: got %h expected 00000014", lo); end
        n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL maddu hi: got %h expected 1", hi); end
        @(negedge clk);
        op = 3'b110; a = 32'd3; b = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b0) nbusy++;
            @(negedge clk);
        end
        n_checks++; if (nbusy !== 0) begin n_fail++; $display("FAIL op110 busy cycles: got %0d expected 0", nbusy); end
        n_checks++; if (lo !== 32'h00000014) begin n_fail++; $display("FAIL op110 lo: got %h expected 00000014", lo); end
`else
        op = 3'b100; a = 32'd3; b = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b0 || done !== 1'b0) nbusy++;
            @(negedge clk);
        end
        n_checks++; if (nbusy !== 0) begin n_fail++; $display("FAIL op100 busy/done cycles: got %0d expected 0", nbusy); end
        n_checks++; if (hi !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL op100 hi: got %h expected fffffffb", hi); end
        n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL op100 lo: got %h expected ffffffff", lo); end
        n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL op100 dvz: got %b expected 1", div_by_zero); end
`endif
    endtask

    task automatic test_dvz_clear();
        int lat, nb; logic z;
        do_op(3'b001, 32'd2, 32'd3, lat, nb, z);
        n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL dvz clear at accept: got %b expected 0", z); end
        n_checks++; if (lo !== 32'd6) begin n_fail++; $display("FAIL multu 2*3 lo: got %h expected 6", lo); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL multu 2*3 hi: got %h expected 0", hi); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL multu 2*3 dvz: got %b expected 0", div_by_zero); end
        @(negedge clk);
    endtask

    task automatic test_ignore_while_busy();
        int ndone;
        logic [31:0] rhi, rlo;
        op = 3'b001; a = 32'd3; b = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; a = 32'd9; b = 32'd9; hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        ndone = 0; rhi = 'x; rlo = 'x;
        for (int i = 0; i < 45; i++) begin
            if (done === 1'b1) begin ndone++; rhi = hi; rlo = lo; end
            @(negedge clk);
        end
        n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL busy-ignore done count: got %0d expected 1", ndone); end
        n_checks++; if (rlo !== 32'd12) begin n_fail++; $display("FAIL busy-ignore lo: got %h expected c", rlo); end
        n_checks++; if (rhi !== 32'd0) begin n_fail++; $display("FAIL busy-ignore hi: got %h expected 0", rhi); end
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAA;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        n_checks++; if (hi !== 32'hAA) begin n_fail++; $display("FAIL mthi hi: got %h expected aa", hi); end
        n_checks++; if (lo !== 32'hAA) begin n_fail++; $display("FAIL mtlo lo: got %h expected aa", lo); end
        hi_we = 1'b1; wdata = 32'h55;
        @(negedge clk);
        hi_we = 1'b0;
        n_checks++; if (hi !== 32'h55) begin n_fail++; $display("FAIL mthi only hi: got %h expected 55", hi); end
        n_checks++; if (lo !== 32'hAA) begin n_fail++; $display("FAIL mthi only lo: got %h expected aa", lo); end
    endtask

    task automatic test_reset_mid_op();
        int nev;
        op = 3'b001; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pre-reset busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async reset busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL async reset done: got %b expected 0", done); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL async reset hi: got %h expected 0", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL async reset lo: got %h expected 0", lo); end
        @(negedge clk);
        rst_n = 1'b1;
        nev = 0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) nev++;
            @(negedge clk);
        end
        n_checks++; if (nev !== 0) begin n_fail++; $display("FAIL post-reset busy/done cycles: got %0d expected 0", nev); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL post-reset lo: got %h expected 0", lo); end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed();
        test_div_zero();
        test_op1xx();
        test_dvz_clear();
        test_ignore_while_busy();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the MIPS datapath; owns the HI/LO register pair.
- Executes MULT, MULTU, DIV and DIVU iteratively, one bit per clock.
- Also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.
- Sits beside the single-cycle ALU; the control unit stalls on busy.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO (minimum 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 1xx see Optional Feature.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO have just been updated by an operation.
- div_by_zero  out  1  last DIV/DIVU had b==0; sticky.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy, done, div_by_zero, hi, lo and all internal registers = 0. Reset mid-operation abandons it; no partial result is written.
- States: IDLE, RUN, FIX.
- IDLE -> RUN: on start=1 with a valid op.
  - Capture the absolute values of a and b (signed ops), the result sign, and op.
  - Set counter=WIDTH, busy=1 from the next cycle.
  - Clear div_by_zero.
- RUN: one iteration per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - counter decrements each cycle. After the WIDTH-th iteration go to FIX.
- FIX (1 cycle):
  - Apply sign correction: two's-complement negate the product if signs differ.
  - Signed divide: quotient negated if signs differ; remainder takes the dividend's sign; quotient truncates toward zero.
  - Write HI/LO, go to IDLE, done=1 for the following cycle only; busy=0 in that same cycle.
- Latency: start sampled at edge k; busy=1 for cycles k+1..k+WIDTH+1; done=1 and new hi/lo visible in cycle k+WIDTH+2 (34 cycles for WIDTH=32).
- Result mapping:
  - Multiply: HI=product[2W-1:W], LO=product[W-1:0].
  - Divide: LO=quotient, HI=remainder.
- Divide by zero: full latency still taken. Result HI=a (original), LO=all ones, div_by_zero=1 until the next accepted start or reset. Applies to signed and unsigned.
- Signed overflow: DIV of most-negative by -1 gives LO=most-negative, HI=0; no flag.
- start while busy: ignored; no queueing.
- start in the same cycle as done: accepted normally.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we write wdata at the clock edge; both may be asserted in the same cycle.
  - While busy, or in the cycle start is accepted, the writes are ignored; the operation result wins.
- hi/lo hold their values except on a FIX write, MTHI/MTLO write or reset.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined:
  - op 100 = MADD (signed) and 101 = MADDU (unsigned): {HI,LO} <= {HI,LO} + product, modulo 2^(2*WIDTH). Same latency as MULT.
  - The accumulate is performed in FIX using the HI/LO values at FIX time.
  - ops 110/111 are ignored.
- Not defined: every op 1xx is ignored when start=1; state stays IDLE, busy stays 0, no flag changes.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, WIDTH=32 -> busy high 33 cycles; done in cycle k+34; HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU a=7 b=2 -> LO=3, HI=1.
- DIVU a=5 b=0 -> div_by_zero=1, HI=5, LO=0xFFFFFFFF. Next MULTU 2*3 -> div_by_zero cleared at accept; LO=6, HI=0.
- Pulse start again, plus hi_we=1 wdata=0x1234, during cycle 5 of a MULTU 3*4 -> both ignored; single done; LO=12, HI=0. Then in IDLE hi_we=lo_we=1 wdata=0xAA -> HI=LO=0xAA.
- Drop rst_n during cycle 10 of RUN -> busy, done, hi, lo immediately 0; no done pulse after rst_n releases.
- With MULDIV_MADD_EN: MTLO 10, MTHI 0, then MADD 3*4 -> LO=22, HI=0. MADD 0xFFFFFFFF*1 on {0,22} -> LO=21, HI=0. Without the macro: op=100 start -> busy stays 0, HI/LO unchanged.
